// File: rtl/heap_alloc_ctrl.sv
// heap_alloc_ctrl
// ---------------------------------------------------------------------------
// Fixed-block heap allocator for the stack machine's shared RAM.
//
// Allocation policy:
//   - New blocks are bump-allocated from the fresh region [HEAP_BASE, HEAP_LIMIT).
//   - Freed blocks are recycled through a singly linked free list kept in RAM.
//   - The first word of a free block holds the address of the next free block.
//   - NULL_ADDR (all ones) terminates the list and is also the address
//     reported when an allocation fails.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   ready          high while idle and accepting a request
//   alloc          one-cycle allocation request, honoured only while ready
//   free           one-cycle free request, honoured only while ready
//   free_address   block to free; held by the requester until done
//   done           registered one-cycle completion pulse
//   alloc_address  allocated block base; valid with done after an alloc
//   alloc_failed   valid with done; 1 = heap exhausted
//   live_blocks    number of blocks currently allocated
//   mem_address    RAM address
//   mem_rw         `RAM_READ / `RAM_WRITE
//   mem_data_in    write data to RAM
//   mem_data_out   read data from RAM, valid one cycle after the address
//
// Optional feature:
//   Define HEAP_ZERO_ON_ALLOC_EN to zero-fill every successfully allocated
//   block. Each word write is held for two cycles before done is raised.
//   Without the macro, blocks are returned with stale contents, including
//   the old list link.
// ---------------------------------------------------------------------------

`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module heap_alloc_ctrl #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 16,
    parameter int HEAP_BASE  = 0,
    parameter int HEAP_LIMIT = 'hF0,
    parameter int ALLOC_SIZE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 alloc,
    input  logic                 free,
    input  logic [ADDR_BITS-1:0] free_address,
    output logic                 done,
    output logic [ADDR_BITS-1:0] alloc_address,
    output logic                 alloc_failed,
    output logic [ADDR_BITS:0]   live_blocks,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rw,
    output logic [DATA_BITS-1:0] mem_data_in,
    input  logic [DATA_BITS-1:0] mem_data_out
);

    localparam logic [ADDR_BITS-1:0] NULL_ADDR  = '1;
    localparam logic [ADDR_BITS-1:0] BASE_ADDR  = ADDR_BITS'(HEAP_BASE);
    localparam logic [ADDR_BITS-1:0] SIZE_ADDR  = ADDR_BITS'(ALLOC_SIZE);
    localparam logic [ADDR_BITS:0]   SIZE_WIDE  = (ADDR_BITS+1)'(ALLOC_SIZE);
    localparam logic [ADDR_BITS:0]   LIMIT_WIDE = (ADDR_BITS+1)'(HEAP_LIMIT);
    localparam logic [ADDR_BITS:0]   ONE_WIDE   = (ADDR_BITS+1)'(1);

`ifdef HEAP_ZERO_ON_ALLOC_EN
    typedef enum logic [1:0] {IDLE, POP, PUSH, ZERO} state_t;

    // One count per write cycle; each word is held for two cycles.
    localparam int             ZC_BITS = $clog2(2 * ALLOC_SIZE) + 1;
    localparam logic [ZC_BITS-1:0] ZC_LAST = ZC_BITS'(2 * ALLOC_SIZE - 1);
    localparam logic [ZC_BITS-1:0] ZC_ONE  = ZC_BITS'(1);

    logic [ZC_BITS-1:0]   zero_cnt_q, zero_cnt_d;
    logic [ADDR_BITS-1:0] zero_base_q, zero_base_d;
`else
    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
`endif

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] heap_end_q, heap_end_d;
    logic [ADDR_BITS-1:0] free_head_q, free_head_d;
    logic [ADDR_BITS:0]   live_blocks_q, live_blocks_d;
    logic                 done_q, done_d;
    logic                 alloc_failed_q, alloc_failed_d;
    logic [ADDR_BITS-1:0] alloc_address_q, alloc_address_d;

    logic bump_ok;
    logic free_ignored;
    logic unused_data_bits;

    // Widened compare so heap_end + ALLOC_SIZE cannot wrap past the limit.
    assign bump_ok      = ({1'b0, heap_end_q} + SIZE_WIDE) <= LIMIT_WIDE;
    assign free_ignored = (free_address == NULL_ADDR) || (live_blocks_q == '0);

    // Only the low ADDR_BITS of a list link are meaningful.
    assign unused_data_bits = ^(mem_data_out >> ADDR_BITS);

    assign done          = done_q;
    assign alloc_address = alloc_address_q;
    assign alloc_failed  = alloc_failed_q;
    assign live_blocks   = live_blocks_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            heap_end_q      <= BASE_ADDR;
            free_head_q     <= NULL_ADDR;
            live_blocks_q   <= '0;
            done_q          <= 1'b0;
            alloc_failed_q  <= 1'b0;
            alloc_address_q <= NULL_ADDR;
`ifdef HEAP_ZERO_ON_ALLOC_EN
            zero_cnt_q      <= '0;
            zero_base_q     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            heap_end_q      <= heap_end_d;
            free_head_q     <= free_head_d;
            live_blocks_q   <= live_blocks_d;
            done_q          <= done_d;
            alloc_failed_q  <= alloc_failed_d;
            alloc_address_q <= alloc_address_d;
`ifdef HEAP_ZERO_ON_ALLOC_EN
            zero_cnt_q      <= zero_cnt_d;
            zero_base_q     <= zero_base_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        heap_end_d      = heap_end_q;
        free_head_d     = free_head_q;
        live_blocks_d   = live_blocks_q;
        done_d          = 1'b0;
        alloc_failed_d  = alloc_failed_q;
        alloc_address_d = alloc_address_q;
`ifdef HEAP_ZERO_ON_ALLOC_EN
        zero_cnt_d      = zero_cnt_q;
        zero_base_d     = zero_base_q;
`endif

        case (state_q)
            IDLE: begin
                // alloc has priority; a simultaneous free is dropped.
                if (alloc) begin
                    if (bump_ok) begin
                        heap_end_d = heap_end_q + SIZE_ADDR;
`ifdef HEAP_ZERO_ON_ALLOC_EN
                        zero_base_d = heap_end_q;
                        zero_cnt_d  = '0;
                        state_d     = ZERO;
`else
                        alloc_address_d = heap_end_q;
                        alloc_failed_d  = 1'b0;
                        live_blocks_d   = live_blocks_q + ONE_WIDE;
                        done_d          = 1'b1;
`endif
                    end else if (free_head_q != NULL_ADDR) begin
                        state_d = POP;
                    end else begin
                        alloc_address_d = NULL_ADDR;
                        alloc_failed_d  = 1'b1;
                        done_d          = 1'b1;
                    end
                end else if (free) begin
                    if (free_ignored) begin
                        alloc_failed_d = 1'b0;
                        done_d         = 1'b1;
                    end else begin
                        state_d = PUSH;
                    end
                end
            end

            POP: begin
                // The link read was addressed in IDLE and is now on mem_data_out.
                free_head_d = mem_data_out[ADDR_BITS-1:0];
`ifdef HEAP_ZERO_ON_ALLOC_EN
                zero_base_d = free_head_q;
                zero_cnt_d  = '0;
                state_d     = ZERO;
`else
                alloc_address_d = free_head_q;
                alloc_failed_d  = 1'b0;
                live_blocks_d   = live_blocks_q + ONE_WIDE;
                done_d          = 1'b1;
                state_d         = IDLE;
`endif
            end

            PUSH: begin
                free_head_d    = free_address;
                live_blocks_d  = live_blocks_q - ONE_WIDE;
                alloc_failed_d = 1'b0;
                done_d         = 1'b1;
                state_d        = IDLE;
            end

`ifdef HEAP_ZERO_ON_ALLOC_EN
            ZERO: begin
                zero_cnt_d = zero_cnt_q + ZC_ONE;
                if (zero_cnt_q == ZC_LAST) begin
                    alloc_address_d = zero_base_q;
                    alloc_failed_d  = 1'b0;
                    live_blocks_d   = live_blocks_q + ONE_WIDE;
                    done_d          = 1'b1;
                    state_d         = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = (state_q == IDLE);
        mem_rw      = `RAM_READ;
        mem_address = '0;
        mem_data_in = '0;

        // Holding reset drops any in-flight access straight away.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (alloc) begin
                        if (!bump_ok && (free_head_q != NULL_ADDR)) begin
                            mem_address = free_head_q;
                        end
                    end else if (free && !free_ignored) begin
                        mem_rw      = `RAM_WRITE;
                        mem_address = free_address;
                        mem_data_in = DATA_BITS'(free_head_q);
                    end
                end

                // Second cycle of the two-cycle link write.
                PUSH: begin
                    mem_rw      = `RAM_WRITE;
                    mem_address = free_address;
                    mem_data_in = DATA_BITS'(free_head_q);
                end

`ifdef HEAP_ZERO_ON_ALLOC_EN
                ZERO: begin
                    mem_rw      = `RAM_WRITE;
                    mem_address = zero_base_q + ADDR_BITS'(zero_cnt_q >> 1);
                    mem_data_in = '0;
                end
`endif

                default: begin
                    mem_rw      = `RAM_READ;
                    mem_address = '0;
                    mem_data_in = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heap_alloc_ctrl.sv
// tb_heap_alloc_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for heap_alloc_ctrl.
//
// Configuration: HEAP_BASE=0, HEAP_LIMIT=4, ALLOC_SIZE=2.
//
// Structure:
//   - The bench owns a one-cycle-latency RAM.
//   - It runs a directed sequence, then randomized alloc/free traffic.
//   - The reference model keeps the bump pointer as an integer and the free
//     list as a LIFO queue.
//
// Ports: none.
// ---------------------------------------------------------------------------

`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module tb_heap_alloc_ctrl;

    localparam int         LIMIT = 4;
    localparam int         SIZE  = 2;
    localparam logic [7:0] NULLA = 8'hFF;
`ifdef HEAP_ZERO_ON_ALLOC_EN
    localparam int ZLAT = 2 * SIZE;
`else
    localparam int ZLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alloc = 1'b0;
    logic        free = 1'b0;
    logic [7:0]  free_address = 8'h00;
    logic        ready, done, alloc_failed, mem_rw;
    logic [7:0]  alloc_address, mem_address;
    logic [8:0]  live_blocks;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out = 16'h0000;

    logic [15:0] ram [0:255];
    int          writeCount = 0;
    int          checkCount = 0;
    int          errorCount = 0;

    int mHeapEnd;
    int mLive;
    int mFree[$];
    int owned[$];

    heap_alloc_ctrl #(
        .ADDR_BITS (8),
        .DATA_BITS (16),
        .HEAP_BASE (0),
        .HEAP_LIMIT(LIMIT),
        .ALLOC_SIZE(SIZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .alloc        (alloc),
        .free         (free),
        .free_address (free_address),
        .done         (done),
        .alloc_address(alloc_address),
        .alloc_failed (alloc_failed),
        .live_blocks  (live_blocks),
        .mem_address  (mem_address),
        .mem_rw       (mem_rw),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data_out <= ram[mem_address];
        if (mem_rw == `RAM_WRITE) begin
            ram[mem_address] <= mem_data_in;
            writeCount       <= writeCount + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        mHeapEnd = 0;
        mLive    = 0;
        mFree.delete();
        owned.delete();
    endfunction

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    // Called at a negedge; issues one request and checks its completion.
    task automatic applyStimulus(input string tag, input bit doAlloc, input bit doFree,
                                 input logic [7:0] addr);
        int         waitCycles;
        int         lat;
        int         wrBase;
        int         expLat;
        int         expWrites;
        int         link;
        bit         expFail;
        bit         freeDone;
        logic [7:0] expAddr;

        waitCycles = 0;
        while (!ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, ".ready"}, ready, 1'b1);

        wrBase       = writeCount;
        alloc        = doAlloc;
        free         = doFree;
        free_address = addr;

        expWrites = 0;
        expFail   = 1'b0;
        expAddr   = NULLA;
        expLat    = 1;
        freeDone  = 1'b0;
        link      = NULLA;

        if (doAlloc) begin
            if (mHeapEnd + SIZE <= LIMIT) begin
                expAddr   = 8'(mHeapEnd);
                mHeapEnd += SIZE;
                mLive++;
                expLat    = 1 + ZLAT;
                expWrites = ZLAT;
                owned.push_back(int'(expAddr));
            end else if (mFree.size() > 0) begin
                expAddr   = 8'(mFree.pop_front());
                mLive++;
                expLat    = 2 + ZLAT;
                expWrites = ZLAT;
                owned.push_back(int'(expAddr));
            end else begin
                expFail = 1'b1;
            end
        end else if (doFree) begin
            if (addr != NULLA && mLive != 0) begin
                link = (mFree.size() > 0) ? mFree[0] : int'(NULLA);
                mFree.push_front(int'(addr));
                mLive--;
                expLat    = 2;
                expWrites = 2;
                freeDone  = 1'b1;
                for (int i = 0; i < owned.size(); i++) begin
                    if (owned[i] == int'(addr)) begin
                        owned.delete(i);
                        break;
                    end
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        alloc = 1'b0;
        free  = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end

        checkOutput({tag, ".done"}, done, 1'b1);
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".failed"}, alloc_failed, expFail);
        if (doAlloc) checkOutput({tag, ".address"}, alloc_address, expAddr);
        checkOutput({tag, ".live"}, live_blocks, mLive);
        checkOutput({tag, ".readyInDone"}, ready, 1'b1);
        checkOutput({tag, ".writes"}, writeCount - wrBase, expWrites);
        if (freeDone) checkOutput({tag, ".link"}, ram[addr], link);
`ifdef HEAP_ZERO_ON_ALLOC_EN
        if (doAlloc && !expFail) begin
            for (int w = 0; w < SIZE; w++) begin
                checkOutput({tag, ".zeroFill"}, ram[expAddr + 8'(w)], 16'h0000);
            end
        end
`endif
    endtask

    initial begin
        int         r;
        logic [7:0] fa;

        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.failed", alloc_failed, 1'b0);
        checkOutput("reset.address", alloc_address, NULLA);
        checkOutput("reset.live", live_blocks, 9'd0);
        checkOutput("reset.ready", ready, 1'b1);
        checkOutput("reset.memRw", mem_rw, `RAM_READ);
        checkOutput("reset.memAddr", mem_address, 8'h00);
        checkOutput("reset.memData", mem_data_in, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] bump allocation and exhaustion");
        applyStimulus("bump0", 1, 0, 8'h00);
        applyStimulus("bump1", 1, 0, 8'h00);
        checkOutput("bump.live2", live_blocks, 9'd2);
        applyStimulus("exhaust0", 1, 0, 8'h00);
        checkOutput("exhaust0.nullAddr", alloc_address, 8'hFF);

        $display("[TB] free list push");
        applyStimulus("free2", 0, 1, 8'h02);
        checkOutput("free2.ram", ram[2], 16'h00FF);
        applyStimulus("free0", 0, 1, 8'h00);
        checkOutput("free0.ram", ram[0], 16'h0002);
        checkOutput("free.live0", live_blocks, 9'd0);

        $display("[TB] free list pop");
        applyStimulus("pop0", 1, 0, 8'h00);
        checkOutput("pop0.addr", alloc_address, 8'h00);
        applyStimulus("pop1", 1, 0, 8'h00);
        checkOutput("pop1.addr", alloc_address, 8'h02);
        applyStimulus("exhaust1", 1, 0, 8'h00);

        $display("[TB] ignored free");
        applyStimulus("freeNull", 0, 1, 8'hFF);
        applyStimulus("freeBack0", 0, 1, 8'h00);
        applyStimulus("freeBack2", 0, 1, 8'h02);
        applyStimulus("freeEmpty", 0, 1, 8'h00);

        $display("[TB] simultaneous alloc and free");
        doReset();
        applyStimulus("both.pre", 1, 0, 8'h00);
        applyStimulus("both", 1, 1, 8'h00);
        checkOutput("both.addr", alloc_address, 8'h02);
        applyStimulus("both.reissue", 0, 1, 8'h00);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (owned.size() > 0) fa = 8'(owned[$urandom_range(0, owned.size() - 1)]);
            else fa = 8'($urandom_range(0, 3));
            if (r <= 4)      applyStimulus("rnd.alloc", 1, 0, fa);
            else if (r <= 7) applyStimulus("rnd.free", 0, 1, fa);
            else if (r == 8) applyStimulus("rnd.freeNull", 0, 1, NULLA);
            else             applyStimulus("rnd.both", 1, 1, fa);
        end

        $display("[TB] reset during a free");
        doReset();
        applyStimulus("abort.pre", 1, 0, 8'h00);
        alloc        = 1'b0;
        free         = 1'b1;
        free_address = 8'h00;
        @(posedge clk);
        @(negedge clk);
        free  = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("abort.memRw", mem_rw, `RAM_READ);
        @(negedge clk);
        checkOutput("abort.done", done, 1'b0);
        checkOutput("abort.live", live_blocks, 9'd0);
        checkOutput("abort.ready", ready, 1'b1);
        reset = 1'b1;
        modelReset();
        applyStimulus("abort.post", 1, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/heap_alloc_ctrl.md
# heap_alloc_ctrl

Second-generation fixed-block heap allocator for the stack machine's shared RAM. It bump-allocates from a fresh region and recycles freed blocks through an in-RAM singly linked free list. Relative to the first-generation allocator it adds:
- parametrised address/data widths and block size;
- an explicit empty-list sentinel, with failure reporting instead of handing out garbage;
- a ready/done request handshake;
- a live-block counter;
- optional zero-fill of allocated blocks.

It sits between the process/channel scheduler (requester) and the RAM port arbiter.

## Interface
Parameters:
- ADDR_BITS, 8, address width; must be ≤ DATA_BITS.
- DATA_BITS, 16, RAM word width.
- HEAP_BASE, 0, first heap address.
- HEAP_LIMIT, 8'hF0, exclusive end of heap; must be < NULL_ADDR.
- ALLOC_SIZE, 1, words per block, ≥ 1.
- NULL_ADDR (localparam), all-ones ADDR_BITS, free-list terminator and failure address.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- ready  out  1  high when idle and accepting a request (combinational, state==IDLE).
- alloc  in  1  single-cycle allocation request, honoured only when ready=1.
- free  in  1  single-cycle free request, honoured only when ready=1.
- free_address  in  ADDR_BITS  block to free; sampled with free, held until done.
- done  out  1  registered one-cycle completion pulse.
- alloc_address  out  ADDR_BITS  allocated block base; valid while done=1 after alloc.
- alloc_failed  out  1  valid with done; 1 = heap exhausted.
- live_blocks  out  ADDR_BITS+1  count of currently allocated blocks.
- mem_address  out  ADDR_BITS  RAM address.
- mem_rw  out  1  `RAM_READ` / `RAM_WRITE`.
- mem_data_in  out  DATA_BITS  write data to RAM.
- mem_data_out  in  DATA_BITS  read data from RAM, valid one cycle after address.

## Operation
Internal state:
- heap_end (reset HEAP_BASE).
- free_head (reset NULL_ADDR).
- FSM: IDLE, POP, PUSH, ZERO (ZERO only with the macro).

Output reset values:
- done=0, alloc_failed=0, alloc_address=NULL_ADDR, live_blocks=0.
- When no access is active: mem_rw=`RAM_READ`, mem_address=0, mem_data_in=0 (no X).

Request handling in IDLE:
- alloc and free together: alloc wins; free is dropped. The requester must re-issue the free.
- **alloc, bump case** (heap_end + ALLOC_SIZE ≤ HEAP_LIMIT, compared in ADDR_BITS+1 bits so the sum cannot wrap): alloc_address←heap_end, heap_end += ALLOC_SIZE, live_blocks++, done.
- **alloc, recycle case** (bump region exhausted, free_head≠NULL_ADDR): drive a read of free_head and go to POP. In POP: free_head←mem_data_out[ADDR_BITS-1:0], alloc_address←old free_head, live_blocks++, done, return to IDLE.
- **alloc, exhausted** (bump region exhausted and free_head=NULL_ADDR): alloc_failed=1, alloc_address=NULL_ADDR, done. Counters are unchanged.
- **free, normal**: write zero-extended free_head to free_address in IDLE, then repeat the identical write in PUSH (two-cycle write hold). At the end of PUSH: free_head←free_address, live_blocks−−, done.
- **free, ignored**: if free_address=NULL_ADDR or live_blocks=0, no RAM access occurs, done pulses with alloc_failed=0, and state is unchanged.

General rules:
- Double free is not detected; the requester owns correctness.
- Reset mid-operation aborts any access immediately and reinitialises all state; an in-flight request is lost without a done pulse.

## Timing
Latencies, with the request accepted at edge N:
- Bump alloc and failed alloc: done at N+1.
- Pop alloc: read address at N, data captured at N+1, done at N+2.
- Free: write cycles N and N+1, done at N+2. free_head updates on the same edge as done.
- ready returns high in the cycle done is high, so a new request may be issued in that cycle.
- Zero-fill, when enabled, adds 2·ALLOC_SIZE cycles before done.

## Configuration
- HEAP_ZERO_ON_ALLOC_EN defined:
  - Every successful alloc enters ZERO before done.
  - Each word alloc_address..alloc_address+ALLOC_SIZE−1 is written with 0, each write held for 2 cycles.
  - done, live_blocks and alloc_address update after the last word.
- Undefined: the ZERO state and its word counter are absent, and blocks are returned with stale contents (including the old list link).

## Test plan
- Reset, HEAP_BASE=0, HEAP_LIMIT=4, ALLOC_SIZE=2: two allocs return 0 and 2, each done one cycle later; live_blocks=2; third alloc → alloc_failed=1, alloc_address=8'hFF.
- Free 2, then free 0: RAM[2]=FF and RAM[0]=2, each done 2 cycles after acceptance; live_blocks=0.
- Next allocs return 0 then 2 (POP path, done at N+2), then a further alloc fails.
- Same-cycle alloc+free with bump space → only the alloc completes; RAM unchanged; the free must be re-issued.
- free with free_address=FF → done at N+1, no mem_rw=`RAM_WRITE` cycle, counters unchanged.
- With HEAP_ZERO_ON_ALLOC_EN, popped block 0 (RAM[0]=2, RAM[1]=5) → both words read 0, done 4 cycles after POP completes.
